accum_xcel_ctrl: RTL and testbench

//  Control unit for the accumulator accelerator; sits directly upstream of the accumulator datapath and drives its control inputs.

---
 rtl/accum_xcel_pkg.sv | 9 +
 rtl/accum_xcel_ctrl_counter.sv | 26 ++
 rtl/accum_xcel_ctrl.sv | 86 ++++++++
 tb/tb_accum_xcel_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/accum_xcel_pkg.sv
// Shared types and constants for the accumulator accelerator control unit.
package accum_xcel_pkg;

  typedef enum logic [1:0] {IDLE, INIT, ACCUM, DONE} accum_state_t;

  localparam logic [15:0] START_ADDR_DEFAULT = 16'h0000;
  localparam logic [15:0] RUN_CYCLES_MAX     = 16'hFFFF;

endpackage

// File: rtl/accum_xcel_ctrl_counter.sv
// 16-bit loadable up-counter (the Counter_16b_RTL block) with synchronous reset.
module accum_xcel_ctrl_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic [15:0] incr,
  output logic [15:0] count
);

  logic [15:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 16'h0000;
    end else if (load) begin
      count_q <= load_value;
    end else if (en) begin
      count_q <= count_q + incr;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/accum_xcel_ctrl.sv
// Control FSM for the accumulator accelerator: sequences INIT/ACCUM/DONE for the datapath
// and tracks ACCUM cycles per run.
module accum_xcel_ctrl
  import accum_xcel_pkg::*;
#(
  parameter logic [15:0] START_ADDR = START_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  output logic        busy,
  output logic        done,
  output logic [15:0] run_cycles,
  input  logic        mem_rdy,
  input  logic        equal,
  output logic        addr_counter_load,
  output logic [15:0] addr_counter_start,
  output logic        mem_val,
  output logic        add_en,
  output logic        rst_sel
);

  accum_state_t state_q, state_d;
  logic         cnt_load;
  logic         cnt_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    busy              = 1'b0;
    done              = 1'b0;
    addr_counter_load = 1'b0;
    mem_val           = 1'b0;
    add_en            = 1'b0;
    rst_sel           = 1'b0;
    cnt_load          = 1'b0;
    cnt_en            = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) state_d = INIT;
      end
      INIT: begin
        busy              = 1'b1;
        addr_counter_load = 1'b1;
        rst_sel           = 1'b1;
        add_en            = 1'b1;
        cnt_load          = 1'b1;
        state_d           = ACCUM;
      end
      ACCUM: begin
        busy    = 1'b1;
        // equal wins over mem_rdy: the final word has already been consumed
        mem_val = mem_rdy & ~equal;
        add_en  = mem_rdy & ~equal;
        cnt_en  = (run_cycles != RUN_CYCLES_MAX);
        if (equal) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign addr_counter_start = START_ADDR;

  accum_xcel_ctrl_counter u_run_cycles (
    .clk        (clk),
    .rst        (rst),
    .en         (cnt_en),
    .load       (cnt_load),
    .load_value (16'h0000),
    .incr       (16'h0001),
    .count      (run_cycles)
  );

endmodule

// File: tb/tb_accum_xcel_ctrl.sv
// Randomized bench for accum_xcel_ctrl driving a behavioural accumulator datapath; each run is
// checked against totals (sum, latency, cycle count) predicted from the word count and stalls.
module tb_accum_xcel_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic        busy;
  logic        done;
  logic [15:0] run_cycles;
  logic        mem_rdy;
  logic        equal;
  logic        addr_counter_load;
  logic [15:0] addr_counter_start;
  logic        mem_val;
  logic        add_en;
  logic        rst_sel;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] in_size;
  logic [7:0]  mem [16];
  int          stall_before [16];
  logic [15:0] dp_addr;
  logic [15:0] dp_acc;

  always #5 clk = ~clk;

  accum_xcel_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .go                 (go),
    .busy               (busy),
    .done               (done),
    .run_cycles         (run_cycles),
    .mem_rdy            (mem_rdy),
    .equal              (equal),
    .addr_counter_load  (addr_counter_load),
    .addr_counter_start (addr_counter_start),
    .mem_val            (mem_val),
    .add_en             (add_en),
    .rst_sel            (rst_sel)
  );

  // Behavioural datapath: address counter plus accumulation register.
  assign equal = (dp_addr == (in_size << 2));

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_addr <= 16'h0000;
      dp_acc  <= 16'h0000;
    end else begin
      if (addr_counter_load) dp_addr <= addr_counter_start;
      else if (mem_val)      dp_addr <= dp_addr + 16'd4;
      if (add_en) dp_acc <= rst_sel ? 16'h0000 : dp_acc + {8'h00, mem[dp_addr[5:2]]};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_ctrl_idle(input string tag);
    check({tag, ".ctrl"}, {addr_counter_load, mem_val, add_en, rst_sel}, 4'b0000);
  endtask

  // Starts in cycle 0 (IDLE); returns at the sample point of the IDLE cycle after DONE.
  // go_mode: 0 = single pulse, 1 = random go while busy (always in DONE), 2 = go held high.
  task automatic do_run(input int n, input int go_mode);
    int          s;
    int          d;
    int          w;
    int          r;
    int          exp_rc;
    logic [15:0] exp_sum;
    s       = 0;
    exp_sum = 16'h0000;
    for (int i = 0; i < n; i++) begin
      s       += stall_before[i];
      exp_sum += {8'h00, mem[i]};
    end
    d       = n + 3 + s;
    exp_rc  = (n + 1 + s > 65535) ? 65535 : n + 1 + s;
    in_size = 16'(n);
    go      = 1'b1;
    mem_rdy = 1'($urandom);
    w       = 0;
    r       = stall_before[0];
    for (int c = 1; c <= d + 1; c++) begin
      @(posedge clk);
      #1;
      check("busy", busy, (c <= d) ? 1 : 0);
      check("done", done, (c == d) ? 1 : 0);
      if (c == 1) check("init.load_rstsel", {addr_counter_load, rst_sel}, 2'b11);
      if (c == d) begin
        check("result", dp_acc, exp_sum);
        check("run_cycles", run_cycles, exp_rc);
        check("final_addr", dp_addr, 16'(n * 4));
        check_ctrl_idle("done");
      end
      if (c == d + 1) check_ctrl_idle("idle");
      if (c <= d) begin
        case (go_mode)
          1:       go = (c == d) ? 1'b1 : 1'($urandom);
          2:       go = 1'b1;
          default: go = 1'b0;
        endcase
        if (c >= 2 && w < n) begin
          if (r > 0) begin
            mem_rdy = 1'b0;
            r--;
          end else begin
            mem_rdy = 1'b1;
            w++;
            r = (w < n) ? stall_before[w] : 0;
          end
        end else begin
          mem_rdy = 1'($urandom);
        end
      end
    end
  endtask

  task automatic idle_cycles(input int k);
    go = 1'b0;
    for (int i = 0; i < k; i++) begin
      mem_rdy = 1'($urandom);
      @(posedge clk);
      #1;
      check("gap.busy", busy, 0);
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 16; i++) begin
      mem[i]          = 8'($urandom_range(1, 255));
      stall_before[i] = 0;
    end
  endtask

  initial begin
    rst     = 1'b1;
    go      = 1'b1;
    mem_rdy = 1'b1;
    in_size = 16'd0;
    fill_mem();

    // Reset held two cycles with go high.
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.run_cycles", run_cycles, 0);
    check_ctrl_idle("rst");
    rst = 1'b0;
    go  = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst.busy", busy, 0);
    check("start_addr", addr_counter_start, 16'h0000);
    check_ctrl_idle("post_rst");

    // in_size=4, {1,2,3,4}: done in cycle 7, result 10, run_cycles 5.
    fill_mem();
    mem[0] = 8'd1; mem[1] = 8'd2; mem[2] = 8'd3; mem[3] = 8'd4;
    do_run(4, 0);

    // in_size=0: done in cycle 3, result 0, run_cycles 1.
    idle_cycles(2);
    fill_mem();
    do_run(0, 0);

    // in_size=2, {7,9}, three stall cycles mid-ACCUM: done in cycle 8, run_cycles 6.
    fill_mem();
    mem[0] = 8'd7; mem[1] = 8'd9; stall_before[1] = 3;
    do_run(2, 0);

    // go during ACCUM and DONE ignored; the next run re-zeroes the result.
    fill_mem();
    do_run(5, 1);
    fill_mem();
    mem[0] = 8'd5;
    do_run(1, 0);

    // go held high: back-to-back runs with one IDLE cycle between.
    fill_mem();
    do_run(3, 2);
    fill_mem();
    do_run(2, 2);

    // Reset in the third ACCUM cycle.
    fill_mem();
    in_size = 16'd5;
    go      = 1'b1;
    mem_rdy = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      check("pre_rst.busy", busy, 1);
      go = 1'b0;
      if (c == 4) rst = 1'b1;
    end
    @(posedge clk);
    #1;
    check("mid_rst.busy", busy, 0);
    check("mid_rst.done", done, 0);
    check("mid_rst.run_cycles", run_cycles, 0);
    check_ctrl_idle("mid_rst");
    rst = 1'b0;
    fill_mem();
    mem[0] = 8'd1; mem[1] = 8'd1; mem[2] = 8'd1;
    do_run(3, 0);

    // Randomized runs with random stalls, go behaviour and idle gaps.
    for (int k = 0; k < 25; k++) begin
      fill_mem();
      for (int i = 0; i < 16; i++) stall_before[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
      do_run($urandom_range(0, 8), $urandom_range(0, 2));
    end

    // run_cycles saturates instead of wrapping.
    fill_mem();
    stall_before[0] = 65540;
    do_run(1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
